// File: rtl/graph_window_edges.sv
// Streaming contact-graph edge counter: each accepted ID is paired with every ID in a sliding
// window of recent IDs, and unique pairs are recorded in a bounded edge table.
module graph_window_edges #(
  parameter int unsigned POPSIZE    = 100,
  parameter int unsigned WINSIZE    = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 11,
  parameter int unsigned MAX_EDGES  = 64,
  parameter bit          DIRECTED   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [ID_WIDTH-1:0]   id_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] num_edges,
  output logic                  overflow,
  output logic                  id_err
);

  localparam int unsigned FillW = $clog2(WINSIZE + 1);
  localparam logic [ID_WIDTH-1:0] PopLim = ID_WIDTH'(POPSIZE);

  typedef enum logic [1:0] {StIdle, StScan, StUpdate} state_e;

  state_e                state_q, state_d;
  logic [FillW-1:0]      fill_q, fill_d, idx_q, idx_d;
  logic [ID_WIDTH-1:0]   cur_q, cur_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  out_valid_q, out_valid_d;
  logic                  id_err_q, id_err_d;

  logic [ID_WIDTH-1:0]   win_q   [WINSIZE];
  logic [ID_WIDTH-1:0]   tbl_a_q [MAX_EDGES];
  logic [ID_WIDTH-1:0]   tbl_b_q [MAX_EDGES];

  logic [ID_WIDTH-1:0]   slot, pair_a, pair_b;
  logic                  hit, full, tbl_we, win_shift;

  always_comb begin
    slot = '0;
    for (int i = 0; i < WINSIZE; i++) begin
      if (idx_q == FillW'(i)) slot = win_q[i];
    end
    if (DIRECTED) begin
      pair_a = slot;
      pair_b = cur_q;
    end else begin
      pair_a = (slot < cur_q) ? slot : cur_q;
      pair_b = (slot < cur_q) ? cur_q : slot;
    end
    // Only entries below the write pointer hold live pairs.
    hit = 1'b0;
    for (int i = 0; i < MAX_EDGES; i++) begin
      if (DATA_WIDTH'(i) < count_q && tbl_a_q[i] == pair_a && tbl_b_q[i] == pair_b) hit = 1'b1;
    end
    full = (count_q == DATA_WIDTH'(MAX_EDGES));
  end

  assign in_ready = (state_q == StIdle) && !clr && rst;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    id_err_d    = 1'b0;
    tbl_we      = 1'b0;
    win_shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          if (id_in >= PopLim) begin
            id_err_d = 1'b1;
          end else begin
            cur_d = id_in;
            idx_d = '0;
            if (fill_q != '0) begin
              state_d = StScan;
            end else begin
              state_d     = StUpdate;
              out_valid_d = 1'b1;
            end
          end
        end
      end
      StScan: begin
        if (slot != cur_q && !hit) begin
          if (!full) begin
            tbl_we  = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (idx_q == fill_q - FillW'(1)) begin
          state_d     = StUpdate;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + FillW'(1);
        end
      end
      StUpdate: begin
        win_shift = 1'b1;
        if (fill_q != FillW'(WINSIZE)) fill_d = fill_q + FillW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (clr) begin
      state_d     = StIdle;
      fill_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b0;
      id_err_d    = 1'b0;
      tbl_we      = 1'b0;
      win_shift   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      fill_q      <= '0;
      idx_q       <= '0;
      cur_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      id_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      id_err_q    <= id_err_d;
    end
  end

  // Window and table contents need no reset: fill and count gate which entries are live.
  always_ff @(posedge clk) begin
    if (win_shift) begin
      if (fill_q == FillW'(WINSIZE)) begin
        for (int i = 0; i < WINSIZE - 1; i++) win_q[i] <= win_q[i+1];
        win_q[WINSIZE-1] <= cur_q;
      end else begin
        for (int i = 0; i < WINSIZE; i++) begin
          if (fill_q == FillW'(i)) win_q[i] <= cur_q;
        end
      end
    end
    for (int i = 0; i < MAX_EDGES; i++) begin
      if (tbl_we && count_q == DATA_WIDTH'(i)) begin
        tbl_a_q[i] <= pair_a;
        tbl_b_q[i] <= pair_b;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign num_edges = count_q;
  assign overflow  = overflow_q;
  assign id_err    = id_err_q;

endmodule
